// File: rtl/scaler_pkg.sv
// Shared defaults and sizing helpers for the horizontal scaler.
package scaler_pkg;

    localparam int DEF_PIXEL_STEP        = 1024;
    localparam int DEF_TABLE_INPUT_WIDTH = 8;
    localparam int DEF_PIXEL_WIDTH       = 8;
    localparam int IDX_WIDTH             = 13;
    localparam int SYNC_LAT              = 3;

    // Number of fraction bits in the position accumulator.
    function automatic int frac_bits(input int pixel_step);
        return $clog2(pixel_step);
    endfunction

    // Width of the position accumulator P.
    function automatic int acc_width();
        return 24;
    endfunction

endpackage

// File: rtl/scaler_h_interp.sv
// Two-stage 2-tap linear interpolator: weighted sum, then round and clamp.
module scaler_h_interp
    import scaler_pkg::*;
#(
    parameter int PIXEL_WIDTH       = DEF_PIXEL_WIDTH,
    parameter int TABLE_INPUT_WIDTH = DEF_TABLE_INPUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIXEL_WIDTH-1:0]       prev,
    input  logic [PIXEL_WIDTH-1:0]       cur,
    input  logic [TABLE_INPUT_WIDTH-1:0] frac,
    input  logic                         vld,
    output logic [PIXEL_WIDTH-1:0]       pix,
    output logic                         pix_vld
);

    localparam int SUM_W = PIXEL_WIDTH + TABLE_INPUT_WIDTH + 1;
    localparam logic [SUM_W-1:0] WEIGHT_ONE = SUM_W'(1) << TABLE_INPUT_WIDTH;
    localparam logic [SUM_W-1:0] HALF       = SUM_W'(1) << (TABLE_INPUT_WIDTH - 1);
    localparam logic [SUM_W-1:0] PIX_MAX    = SUM_W'({PIXEL_WIDTH{1'b1}});

    logic [SUM_W-1:0] sum_p1;
    logic             vld_p1;

    // Round half-up, drop the weight bits and clamp to the pixel range.
    function automatic logic [PIXEL_WIDTH-1:0] round_sat(input logic [SUM_W-1:0] acc);
        logic [SUM_W-1:0] q;
        q = (acc + HALF) >> TABLE_INPUT_WIDTH;
        if (q > PIX_MAX) begin
            return {PIXEL_WIDTH{1'b1}};
        end
        return q[PIXEL_WIDTH-1:0];
    endfunction

    // Stage p1: weighted sum of the two taps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld;
            if (vld) begin
                sum_p1 <= SUM_W'(prev) * (WEIGHT_ONE - SUM_W'(frac))
                        + SUM_W'(cur) * SUM_W'(frac);
            end
        end
    end

    // Stage p2: rounded output; the pixel value holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix     <= '0;
            pix_vld <= 1'b0;
        end else begin
            pix_vld <= vld_p1;
            if (vld_p1) begin
                pix <= round_sat(sum_p1);
            end
        end
    end

endmodule

// File: rtl/scaler_h.sv
// Horizontal down-scaler: position/index control feeding a 2-tap interpolator,
// with hs/vs delayed to match the data path.
module scaler_h
    import scaler_pkg::*;
#(
    parameter int PIXEL_STEP        = DEF_PIXEL_STEP,
    parameter int TABLE_INPUT_WIDTH = DEF_TABLE_INPUT_WIDTH,
    parameter int PIXEL_WIDTH       = DEF_PIXEL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            scale_step_h,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam int FB    = frac_bits(PIXEL_STEP);
    localparam int ACC_W = acc_width();
    localparam int INT_W = ACC_W - FB;

    // Line state
    logic [ACC_W-1:0]       pos;
    logic [IDX_WIDTH-1:0]   idx;
    logic [15:0]            step;
    logic                   active;
    logic [PIXEL_WIDTH-1:0] prev;

    // Effective values for the current cycle (a line start overrides the state)
    logic [ACC_W-1:0]     line_pos;
    logic [IDX_WIDTH-1:0] line_idx;
    logic [15:0]          line_step;
    logic                 take;
    logic                 emit;

    // Stage p0 registers
    logic [PIXEL_WIDTH-1:0]       prev_p0;
    logic [PIXEL_WIDTH-1:0]       cur_p0;
    logic [TABLE_INPUT_WIDTH-1:0] frac_p0;
    logic                         vld_p0;

    logic [SYNC_LAT-1:0] hs_dly;
    logic [SYNC_LAT-1:0] vs_dly;

    // Decide whether this pixel is the right tap of the next output sample.
    always_comb begin
        line_pos  = hs_i ? '0 : pos;
        line_idx  = hs_i ? '0 : idx;
        line_step = hs_i ? scale_step_h : step;
        take      = de_i && (active || hs_i);
        emit      = take && (line_idx != '0)
                    && (line_pos[ACC_W-1:FB] == INT_W'(line_idx - IDX_WIDTH'(1)));
    end

    // Advance position, index and previous pixel; ignore pixels until a line start.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            pos    <= '0;
            idx    <= '0;
            step   <= '0;
            prev   <= '0;
        end else begin
            if (hs_i) begin
                active <= 1'b1;
                pos    <= '0;
                idx    <= '0;
                step   <= scale_step_h;
            end
            if (take) begin
                prev <= di_i;
                idx  <= line_idx + IDX_WIDTH'(1);
                if (emit) begin
                    pos <= line_pos + ACC_W'(line_step);
                end
            end
        end
    end

    // Stage p0: taps and weight handed to the interpolator.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p0 <= '0;
            cur_p0  <= '0;
            frac_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= emit;
            if (emit) begin
                prev_p0 <= prev;
                cur_p0  <= di_i;
                frac_p0 <= line_pos[FB-1 -: TABLE_INPUT_WIDTH];
            end
        end
    end

    // Sync delay line matching the three-register data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_dly <= '0;
            vs_dly <= '0;
        end else begin
            hs_dly <= {hs_dly[SYNC_LAT-2:0], hs_i};
            vs_dly <= {vs_dly[SYNC_LAT-2:0], vs_i};
        end
    end

    assign hs_o = hs_dly[SYNC_LAT-1];
    assign vs_o = vs_dly[SYNC_LAT-1];

    scaler_h_interp #(
        .PIXEL_WIDTH       (PIXEL_WIDTH),
        .TABLE_INPUT_WIDTH (TABLE_INPUT_WIDTH)
    ) u_interp (
        .clk     (clk),
        .rst     (rst),
        .prev    (prev_p0),
        .cur     (cur_p0),
        .frac    (frac_p0),
        .vld     (vld_p0),
        .pix     (do_o),
        .pix_vld (de_o)
    );

endmodule

// File: tb/tb_scaler_h.sv
// Self-checking bench for scaler_h: randomized lines against a behavioural model.
module tb_scaler_h;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] scale_step_h = 16'd2048;
    logic [7:0]  di_i = 8'd0;
    logic        de_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [7:0]  do_o;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;

    scaler_h #(.PIXEL_STEP(1024), .TABLE_INPUT_WIDTH(8), .PIXEL_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .scale_step_h(scale_step_h),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int obs_val[$];
    int obs_cyc[$];
    int exp_val[$];
    int exp_cyc[$];
    bit hs_in_h[65536];
    bit vs_in_h[65536];
    bit hs_out_h[65536];
    bit vs_out_h[65536];
    bit vs_lvl = 1'b0;

    // Record driven syncs, observed syncs and every output pixel with its cycle.
    always @(negedge clk) begin
        if (cyc < 65536) begin
            hs_in_h[cyc]  <= hs_i;
            vs_in_h[cyc]  <= vs_i;
            hs_out_h[cyc] <= hs_o;
            vs_out_h[cyc] <= vs_o;
        end
        if (de_o === 1'b1) begin
            obs_val.push_back(int'(do_o));
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit hs_v, input bit de_v, input logic [7:0] px);
        @(posedge clk);
        #1;
        hs_i = hs_v;
        de_i = de_v;
        di_i = px;
        vs_i = vs_lvl;
        // step must only matter at line start, so scramble it elsewhere
        if (!hs_v) scale_step_h = 16'($urandom_range(1024, 65535));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic clear_sb();
        obs_val.delete();
        obs_cyc.delete();
        exp_val.delete();
        exp_cyc.delete();
    endtask

    // Drive one line and queue the expected outputs: output k sits at
    // position k*step; its left tap is floor(pos) and it appears 3 cycles
    // after the right tap pixel arrives.
    task automatic send_line(input int w, input int step, input bit rnd,
                             input int period, input bit hs_with_pix, input int gap);
        int pix[$];
        int pc[$];
        int v;
        scale_step_h = 16'(step);
        if (!hs_with_pix) drive(1'b1, 1'b0, 8'd0);
        for (int j = 0; j < w; j++) begin
            v = rnd ? int'($urandom_range(0, 255)) : (j % 256);
            drive((j == 0) && hs_with_pix, 1'b1, 8'(v));
            pix.push_back(v);
            pc.push_back(cyc);
            if (period > 1) idle(period - 1);
        end
        idle(gap);
        for (int k = 0; k < 100000; k++) begin
            longint p;
            int left;
            int f;
            p = longint'(k) * longint'(step);
            left = int'(p / 1024);
            if (left + 1 > w - 1) break;
            f = int'(p % 1024) / 4;
            exp_val.push_back((pix[left] * (256 - f) + pix[left + 1] * f + 128) / 256);
            exp_cyc.push_back(pc[left + 1] + 3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (do_o !== 8'd0) begin errors++; $display("FAIL reset_do: got %0d expected 0", do_o); end
        checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_de: got %0b expected 0", de_o); end
        checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hs: got %0b expected 0", hs_o); end
        checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vs: got %0b expected 0", vs_o); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
        for (int j = 0; j < 20; j++) drive(1'b0, 1'b1, 8'(j + 1));
        idle(6);
        checks++;
        if (obs_val.size() != 0) begin
            errors++; $display("FAIL no_hs_ignored: got %0d outputs expected 0", obs_val.size());
        end
    endtask

    task automatic test_ramp_half();
        int c0;
        clear_sb();
        c0 = cyc + 1;
        send_line(600, 2048, 1'b0, 1, 1'b0, 10);
        checks++;
        if (obs_val.size() != 300) begin
            errors++; $display("FAIL half_count: got %0d expected 300", obs_val.size());
        end
        for (int k = 0; k < obs_val.size() && k < exp_cyc.size(); k++) begin
            checks++;
            if (obs_val[k] !== (2 * k) % 256) begin
                errors++; $display("FAIL half_val[%0d]: got %0d expected %0d", k, obs_val[k], (2 * k) % 256);
            end
            checks++;
            if (obs_cyc[k] !== exp_cyc[k]) begin
                errors++; $display("FAIL half_lat[%0d]: got cycle %0d expected %0d", k, obs_cyc[k], exp_cyc[k]);
            end
        end
        for (int c = c0; c < cyc - 5; c++) begin
            checks++;
            if (hs_out_h[c + 3] !== hs_in_h[c]) begin
                errors++; $display("FAIL half_hs[%0d]: got %0b expected %0b", c + 3, hs_out_h[c + 3], hs_in_h[c]);
            end
        end
    endtask

    task automatic test_ramp_unity();
        clear_sb();
        send_line(600, 1024, 1'b0, 1, 1'b1, 10);
        checks++;
        if (obs_val.size() != 599) begin
            errors++; $display("FAIL unity_count: got %0d expected 599", obs_val.size());
        end
        for (int k = 0; k < obs_val.size() && k < exp_cyc.size(); k++) begin
            checks++;
            if (obs_val[k] !== k % 256) begin
                errors++; $display("FAIL unity_val[%0d]: got %0d expected %0d", k, obs_val[k], k % 256);
            end
            checks++;
            if (obs_cyc[k] !== exp_cyc[k]) begin
                errors++; $display("FAIL unity_lat[%0d]: got cycle %0d expected %0d", k, obs_cyc[k], exp_cyc[k]);
            end
        end
    endtask

    task automatic test_random_step();
        int ws[6];
        int ss[6];
        int n0;
        int want;
        ws = '{600, 1, 2, 300, 0, 0};
        ss = '{2730, 2048, 3000, 65535, 0, 0};
        ws[4] = $urandom_range(2, 400); ss[4] = $urandom_range(1024, 8000);
        ws[5] = $urandom_range(2, 400); ss[5] = $urandom_range(1024, 8000);
        clear_sb();
        for (int l = 0; l < 6; l++) begin
            n0 = obs_val.size();
            send_line(ws[l], ss[l], 1'b1, 1, l[0], 8);
            want = ((ws[l] - 1) * 1024 + ss[l] - 1) / ss[l];
            checks++;
            if (obs_val.size() - n0 != want) begin
                errors++; $display("FAIL rnd_count[w=%0d step=%0d]: got %0d expected %0d", ws[l], ss[l], obs_val.size() - n0, want);
            end
        end
        checks++;
        if (obs_val.size() != exp_val.size()) begin
            errors++; $display("FAIL rnd_total: got %0d expected %0d", obs_val.size(), exp_val.size());
        end
        for (int k = 0; k < obs_val.size() && k < exp_val.size(); k++) begin
            checks++;
            if (obs_val[k] !== exp_val[k]) begin
                errors++; $display("FAIL rnd_val[%0d]: got %0d expected %0d", k, obs_val[k], exp_val[k]);
            end
            checks++;
            if (obs_cyc[k] !== exp_cyc[k]) begin
                errors++; $display("FAIL rnd_lat[%0d]: got cycle %0d expected %0d", k, obs_cyc[k], exp_cyc[k]);
            end
        end
    endtask

    task automatic test_de_gaps();
        for (int per = 2; per <= 4; per += 2) begin
            clear_sb();
            send_line(600, 2048, 1'b0, per, 1'b0, 10);
            checks++;
            if (obs_val.size() != 300) begin
                errors++; $display("FAIL gap%0d_count: got %0d expected 300", per, obs_val.size());
            end
            for (int k = 0; k < obs_val.size() && k < exp_cyc.size(); k++) begin
                checks++;
                if (obs_val[k] !== (2 * k) % 256) begin
                    errors++; $display("FAIL gap%0d_val[%0d]: got %0d expected %0d", per, k, obs_val[k], (2 * k) % 256);
                end
                checks++;
                if (obs_cyc[k] !== exp_cyc[k]) begin
                    errors++; $display("FAIL gap%0d_lat[%0d]: got cycle %0d expected %0d", per, k, obs_cyc[k], exp_cyc[k]);
                end
            end
        end
    endtask

    task automatic test_frames();
        int c0;
        int n0;
        clear_sb();
        c0 = cyc + 1;
        for (int fr = 0; fr < 2; fr++) begin
            vs_lvl = 1'b1;
            idle(5);
            for (int l = 0; l < 3; l++) begin
                n0 = obs_val.size();
                send_line(200, 1536, 1'b1, 1, 1'b0, 350);
                checks++;
                if (obs_val.size() - n0 != 133) begin
                    errors++; $display("FAIL frame_line_count[%0d.%0d]: got %0d expected 133", fr, l, obs_val.size() - n0);
                end
            end
            vs_lvl = 1'b0;
            idle(20);
        end
        checks++;
        if (obs_val.size() != exp_val.size()) begin
            errors++; $display("FAIL frame_total: got %0d expected %0d", obs_val.size(), exp_val.size());
        end
        for (int k = 0; k < obs_val.size() && k < exp_val.size(); k++) begin
            checks++;
            if (obs_val[k] !== exp_val[k]) begin
                errors++; $display("FAIL frame_val[%0d]: got %0d expected %0d", k, obs_val[k], exp_val[k]);
            end
        end
        for (int c = c0; c < cyc - 5; c++) begin
            checks++;
            if (hs_out_h[c + 3] !== hs_in_h[c] || vs_out_h[c + 3] !== vs_in_h[c]) begin
                errors++; $display("FAIL frame_sync[%0d]: got hs=%0b vs=%0b expected hs=%0b vs=%0b",
                                   c + 3, hs_out_h[c + 3], vs_out_h[c + 3], hs_in_h[c], vs_in_h[c]);
            end
        end
    endtask

    task automatic test_mid_reset();
        vs_lvl = 1'b1;
        scale_step_h = 16'd2048;
        drive(1'b1, 1'b0, 8'd0);
        for (int j = 0; j < 100; j++) drive(1'b0, 1'b1, 8'(j + 50));
        @(posedge clk);
        #1 rst = 1'b1;
        hs_i = 1'b1;
        de_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (do_o !== 8'd0) begin errors++; $display("FAIL midrst_do: got %0d expected 0", do_o); end
        checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL midrst_de: got %0b expected 0", de_o); end
        checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL midrst_hs: got %0b expected 0", hs_o); end
        checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL midrst_vs: got %0b expected 0", vs_o); end
        @(posedge clk);
        #1 rst = 1'b0;
        hs_i = 1'b0;
        de_i = 1'b0;
        vs_lvl = 1'b0;
        clear_sb();
        for (int j = 0; j < 50; j++) drive(1'b0, 1'b1, 8'(j + 9));
        idle(6);
        checks++;
        if (obs_val.size() != 0) begin
            errors++; $display("FAIL midrst_orphan: got %0d outputs expected 0", obs_val.size());
        end
        clear_sb();
        send_line(600, 2048, 1'b0, 1, 1'b0, 10);
        checks++;
        if (obs_val.size() != 300) begin
            errors++; $display("FAIL midrst_count: got %0d expected 300", obs_val.size());
        end
        for (int k = 0; k < obs_val.size(); k++) begin
            checks++;
            if (obs_val[k] !== (2 * k) % 256) begin
                errors++; $display("FAIL midrst_val[%0d]: got %0d expected %0d", k, obs_val[k], (2 * k) % 256);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_half();
        test_ramp_unity();
        test_random_step();
        test_de_gaps();
        test_frames();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
